atm_account_arbiter: RTL and testbench
======================================

Name: atm_account_arbiter

Overview:
- Shares one account-balance bank between N ATM terminal front-ends.
- Arbitrates terminal transaction requests round-robin and serialises them.
- Performs each granted transaction as a read-modify-write on an internal 8-entry x 8-bit balance bank.
- Returns a one-cycle response (balance plus status flags) to the terminal that was served.

Parameters:
- N_TERM, 4, number of requesting terminals (2..8).
- ACCT_W, 3, account index width; bank depth is 2**ACCT_W.
- BAL_W, 8, balance and amount width.
- INIT_BALANCE, 8'd100, value loaded into every account on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_TERM  per-terminal transaction request, level.
- op  in  2*N_TERM  per-terminal opcode, terminal i at [2i+1:2i]. Codes: 01 deposit, 10 withdraw, 11 show balance, 00 illegal.
- card_no  in  ACCT_W*N_TERM  per-terminal account index.
- amount  in  BAL_W*N_TERM  per-terminal transaction amount.
- grant  out  N_TERM  one-hot; pulses 1 cycle when a terminal's request is accepted.
- done  out  1  one-cycle pulse; response fields below are valid in this cycle.
- rsp_id  out  log2(N_TERM)  index of the served terminal.
- rsp_balance  out  BAL_W  account balance after the transaction.
- no_balance  out  1  withdraw was refused because amount > balance.
- overflow  out  1  deposit was refused because the sum exceeds 2**BAL_W-1.
- illegal_op  out  1  opcode was 00.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset (synchronous, active-high):
- All outputs 0.
- Every bank entry = INIT_BALANCE.
- Round-robin pointer = 0.
- FSM = IDLE.
- Reset asserted mid-transaction aborts it: no done pulse, no bank write.

FSM states: IDLE, EXEC, RESP. All outputs are registered.
- IDLE: at a clock edge where req != 0, select the first requester at or after the pointer (cyclic). Latch its id, op, card_no and amount; go to EXEC.
- EXEC: grant[id]=1 for this cycle only.
  - Read bank[card]; compute the result.
  - Write the bank at the end of the cycle if the transaction is accepted.
  - Register the response fields; go to RESP.
- RESP: done=1 with rsp_id, rsp_balance and flags. Pointer <= id+1 mod N_TERM. Go to IDLE.
- Latency: done is asserted 2 cycles after the edge that samples req.
- Throughput: one transaction per 3 cycles.
- busy is 1 in EXEC and RESP.

Handshake:
- A terminal holds req and its operands stable until it sees its grant.
- Operands are latched at the IDLE edge; changes after that have no effect.
- req still high in the IDLE cycle after done is treated as a new transaction.
- Requests arriving while busy wait; they are never dropped.

Arithmetic (BAL_W-bit, unsigned; at most one flag set per done):
- Deposit: if bal+amount > 2**BAL_W-1, no write, overflow=1, rsp_balance=bal. Otherwise write bal+amount. Compute with a BAL_W+1-bit sum.
- Withdraw: if amount > bal, no write, no_balance=1, rsp_balance=bal. amount == bal is allowed and leaves 0. amount 0 is a legal no-change withdraw.
- Show balance: no write; rsp_balance=bal.
- Illegal op: no write; illegal_op=1; rsp_balance=bal.

Boundary conditions:
- Two terminals targeting the same account are serialised; the second transaction sees the first one's write.
- All requesters high: service order follows the pointer, so no terminal waits more than N_TERM transactions.
- Single requester held continuously: served every 3 cycles.

Decomposition:
- Package atm_pkg holds:
  - op code constants OP_NONE=00, OP_DEPOSIT=01, OP_WITHDRAW=10, OP_BALANCE=11;
  - FSM state encoding (2-bit);
  - default widths ACCT_W and BAL_W.
- Sub-module atm_rr_arbiter:
  - inputs: req vector, pointer;
  - outputs: one-hot pick and binary index;
  - purely combinational, reusable.
- Bank, FSM and ALU stay in the top module.

Test Plan:
1. Reset, then T0 show balance on card 2 -> grant[0] 1 cycle later; done 2 cycles after sampling; rsp_id=0, rsp_balance=100, no flags.
2. T1 deposit 4 on card 1, then T1 show balance on card 1 -> rsp_balance 104, then 104; bank[1]=104.
3. T2 withdraw 128 on card 3 -> no_balance=1, rsp_balance=100, bank unchanged. Then withdraw 100 -> rsp_balance=0, no flag.
4. Deposit 200 on card 4 (balance 100) -> overflow=1, rsp_balance=100. Then op 00 -> illegal_op=1, no write.
5. All four terminals request in the same cycle with pointer 0 -> grants in order 0,1,2,3, spaced 3 cycles apart. T0 and T2 both withdraw 30 from card 5 -> T0 sees 70, T2 sees 40.
6. Assert rst in the EXEC cycle of a deposit -> no done; all bank entries 100; pointer 0; the next request is served by the lowest-index requester.

Source files
------------

// File: rtl/atm_account_arbiter_pkg.sv
// Shared constants for the ATM account arbiter: opcodes, FSM encoding,
// default widths and the response flag bundle.
package atm_pkg;

  localparam logic [1:0] OP_NONE     = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;
  localparam logic [1:0] OP_BALANCE  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int ATM_N_TERM = 4;
  localparam int ATM_ACCT_W = 3;
  localparam int ATM_BAL_W  = 8;

  typedef struct packed {
    logic no_balance;
    logic overflow;
    logic illegal_op;
  } rsp_flags_t;

endpackage

// File: rtl/atm_account_arbiter_if.sv
// Terminal-side bus of the account arbiter plus a debug view of the FSM state.
// Handshake: a terminal raises req[i] with its operands and holds both stable
// until it sees grant[i]; the response for that grant arrives with done on the
// following cycle, tagged by rsp_id.
interface atm_account_arbiter_if #(
  parameter int N_TERM = 4,
  parameter int ACCT_W = 3,
  parameter int BAL_W  = 8
);
  localparam int ID_W = $clog2(N_TERM);

  logic [N_TERM-1:0]        req;
  logic [2*N_TERM-1:0]      op;
  logic [ACCT_W*N_TERM-1:0] card_no;
  logic [BAL_W*N_TERM-1:0]  amount;
  logic [N_TERM-1:0]        grant;
  logic                     done;
  logic [ID_W-1:0]          rsp_id;
  logic [BAL_W-1:0]         rsp_balance;
  logic                     no_balance;
  logic                     overflow;
  logic                     illegal_op;
  logic                     busy;
  logic [1:0]               state;

  modport master (
    output req, op, card_no, amount,
    input  grant, done, rsp_id, rsp_balance, no_balance, overflow, illegal_op,
           busy, state
  );

  modport slave (
    input  req, op, card_no, amount,
    output grant, done, rsp_id, rsp_balance, no_balance, overflow, illegal_op,
           busy, state
  );
endinterface

// File: rtl/atm_account_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping cyclically; returns both one-hot and binary forms.
module atm_rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] index
);

  logic             found;
  logic [IDX_W-1:0] slot;

  always_comb begin
    pick  = '0;
    index = '0;
    found = 1'b0;
    slot  = '0;
    for (int k = 0; k < N; k++) begin
      slot = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[slot]) begin
        found       = 1'b1;
        pick[slot]  = 1'b1;
        index       = slot;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// Serialises terminal transactions onto one balance bank: round-robin pick,
// read-modify-write in EXEC, one-cycle registered response in RESP.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int N_TERM = ATM_N_TERM,
  parameter int ACCT_W = ATM_ACCT_W,
  parameter int BAL_W  = ATM_BAL_W,
  parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(100)
) (
  input logic clk,
  input logic rst,
  atm_account_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_TERM);
  localparam int DEPTH = 1 << ACCT_W;

  logic [1:0]        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id_q;
  logic [1:0]        op_q;
  logic [ACCT_W-1:0] card_q;
  logic [BAL_W-1:0]  amt_q;
  logic [BAL_W-1:0]  bank [DEPTH];

  logic [N_TERM-1:0] grant_q;
  logic              done_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [BAL_W-1:0]  rsp_bal_q;
  rsp_flags_t        flags_q;
  logic              busy_q;

  logic [N_TERM-1:0] pick;
  logic [ID_W-1:0]   pick_idx;
  logic [1:0]        sel_op;
  logic [ACCT_W-1:0] sel_card;
  logic [BAL_W-1:0]  sel_amt;

  atm_rr_arbiter #(.N(N_TERM)) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .pick  (pick),
    .index (pick_idx)
  );

  always_comb begin
    sel_op   = '0;
    sel_card = '0;
    sel_amt  = '0;
    for (int k = 0; k < N_TERM; k++) begin
      if (pick_idx == ID_W'(k)) begin
        sel_op   = bus.op[2*k +: 2];
        sel_card = bus.card_no[ACCT_W*k +: ACCT_W];
        sel_amt  = bus.amount[BAL_W*k +: BAL_W];
      end
    end
  end

  // ALU: refused transactions report the unchanged balance and skip the write.
  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W:0]   sum;
  logic [BAL_W-1:0] new_bal;
  logic             wr_en;
  rsp_flags_t       flags;

  assign cur_bal = bank[card_q];
  assign sum     = {1'b0, cur_bal} + {1'b0, amt_q};

  always_comb begin
    new_bal = cur_bal;
    wr_en   = 1'b0;
    flags   = '0;
    case (op_q)
      OP_DEPOSIT: begin
        if (sum[BAL_W]) begin
          flags.overflow = 1'b1;
        end else begin
          new_bal = sum[BAL_W-1:0];
          wr_en   = 1'b1;
        end
      end
      OP_WITHDRAW: begin
        if (amt_q > cur_bal) begin
          flags.no_balance = 1'b1;
        end else begin
          new_bal = cur_bal - amt_q;
          wr_en   = 1'b1;
        end
      end
      OP_BALANCE: ;
      default: flags.illegal_op = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      op_q      <= OP_NONE;
      card_q    <= '0;
      amt_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      rsp_id_q  <= '0;
      rsp_bal_q <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        bank[a] <= INIT_BALANCE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (|bus.req) begin
            id_q    <= pick_idx;
            op_q    <= sel_op;
            card_q  <= sel_card;
            amt_q   <= sel_amt;
            grant_q <= pick;
            busy_q  <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          grant_q <= '0;
          if (wr_en) begin
            bank[card_q] <= new_bal;
          end
          rsp_id_q  <= id_q;
          rsp_bal_q <= new_bal;
          flags_q   <= flags;
          done_q    <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          ptr    <= (id_q == ID_W'(N_TERM - 1)) ? '0 : id_q + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_balance = rsp_bal_q;
  assign bus.no_balance  = flags_q.no_balance;
  assign bus.overflow    = flags_q.overflow;
  assign bus.illegal_op  = flags_q.illegal_op;
  assign bus.busy        = busy_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Bench for atm_account_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based account model.
module tb_atm_account_arbiter;
  import atm_pkg::*;

  localparam int N     = 4;
  localparam int AW    = 3;
  localparam int BW    = 8;
  localparam int DEPTH = 8;
  localparam int EXP_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  atm_account_arbiter_if #(.N_TERM(N), .ACCT_W(AW), .BAL_W(BW)) bus ();

  atm_account_arbiter #(
    .N_TERM(N), .ACCT_W(AW), .BAL_W(BW), .INIT_BALANCE(8'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int         model_bank [DEPTH];
  int         model_ptr;
  bit         pending [N];
  logic [1:0] t_op [N];
  int         t_card [N];
  int         t_amt [N];

  logic [EXP_W-1:0] exp_q[$];
  int last_grant_cyc;
  int grant_log[$];
  int grant_cyc_log[$];
  int rsp_by_id [N];
  int last_bal;
  logic [2:0] last_flags;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick();
    int best = -1;
    for (int k = 0; k < N; k++) begin
      if (best < 0 && pending[(model_ptr + k) % N]) best = (model_ptr + k) % N;
    end
    return best;
  endfunction

  // Returns {no_balance, overflow, illegal_op, balance} and updates the bank.
  function automatic logic [10:0] model_exec(int t);
    int b = model_bank[t_card[t]];
    int a = t_amt[t];
    logic [2:0] f = 3'b000;
    case (t_op[t])
      OP_DEPOSIT:  if (b + a > 255) f = 3'b010; else b = b + a;
      OP_WITHDRAW: if (a > b) f = 3'b100; else b = b - a;
      OP_BALANCE:  ;
      default:     f = 3'b001;
    endcase
    model_bank[t_card[t]] = b;
    return {f, b[7:0]};
  endfunction

  task automatic monitor();
    logic [EXP_W-1:0] e;
    logic [10:0] r;
    int exp_id;
    int gi;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e[13:11]));
        check("rsp_balance", 32'(bus.rsp_balance), 32'(e[7:0]));
        check("rsp_flags", 32'({bus.no_balance, bus.overflow, bus.illegal_op}), 32'(e[10:8]));
        check("done_latency", cyc - last_grant_cyc, 1);
        check("busy_resp", 32'(bus.busy), 1);
        last_bal   = int'(bus.rsp_balance);
        last_flags = {bus.no_balance, bus.overflow, bus.illegal_op};
        rsp_by_id[bus.rsp_id] = int'(bus.rsp_balance);
      end
    end else if (exp_q.size() > 0 && cyc - last_grant_cyc >= 2) begin
      check("done_missing", 0, 1);
      void'(exp_q.pop_front());
    end
    if (bus.grant != '0) begin
      gi = -1;
      for (int k = 0; k < N; k++) if (bus.grant[k]) gi = k;
      grant_log.push_back(gi);
      grant_cyc_log.push_back(cyc);
      exp_id = model_pick();
      if (exp_id < 0) begin
        check("grant_unexpected", 32'(bus.grant), 0);
      end else begin
        check("grant", 32'(bus.grant), 32'(1) << exp_id);
        check("busy_exec", 32'(bus.busy), 1);
        r = model_exec(exp_id);
        exp_q.push_back({3'(exp_id), r});
        pending[exp_id] = 1'b0;
        bus.req[exp_id] = 1'b0;
        model_ptr = (exp_id + 1) % N;
        last_grant_cyc = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic post(int t, logic [1:0] o, int card, int amt);
    pending[t] = 1'b1;
    t_op[t]    = o;
    t_card[t]  = card;
    t_amt[t]   = amt;
    bus.op[2*t +: 2]       = o;
    bus.card_no[AW*t +: AW] = AW'(card);
    bus.amount[BW*t +: BW]  = BW'(amt);
    bus.req[t] = 1'b1;
  endtask

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int k = 0; k < N; k++) p |= pending[k];
    return p;
  endfunction

  task automatic wait_idle(string tag, int budget);
    int n = 0;
    while ((any_pending() || exp_q.size() > 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    for (int k = 0; k < N; k++) pending[k] = 1'b0;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) model_bank[a] = 100;
    model_ptr = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int amt;
    int card;
    bus.req = '0;
    bus.op = '0;
    bus.card_no = '0;
    bus.amount = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rsp_balance", 32'(bus.rsp_balance), 0);
    check("rst_flags", 32'({bus.no_balance, bus.overflow, bus.illegal_op}), 0);

    // 1: show balance, latency
    post(0, OP_BALANCE, 2, 0);
    tick();
    check("s1_grant", 32'(bus.grant), 32'h1);
    tick();
    check("s1_done", 32'(bus.done), 1);
    check("s1_rsp_id", 32'(bus.rsp_id), 0);
    check("s1_bal", last_bal, 100);
    check("s1_flags", 32'(last_flags), 0);
    wait_idle("s1_idle", 20);

    // 2: deposit then show
    post(1, OP_DEPOSIT, 1, 4);
    wait_idle("s2a_idle", 20);
    check("s2_dep_bal", last_bal, 104);
    post(1, OP_BALANCE, 1, 0);
    wait_idle("s2b_idle", 20);
    check("s2_show_bal", last_bal, 104);

    // 3: refused then exact withdraw
    post(2, OP_WITHDRAW, 3, 128);
    wait_idle("s3a_idle", 20);
    check("s3_refused_bal", last_bal, 100);
    check("s3_refused_flags", 32'(last_flags), 32'b100);
    post(2, OP_WITHDRAW, 3, 100);
    wait_idle("s3b_idle", 20);
    check("s3_exact_bal", last_bal, 0);
    check("s3_exact_flags", 32'(last_flags), 0);

    // 4: overflow, illegal, balance unchanged
    post(3, OP_DEPOSIT, 4, 200);
    wait_idle("s4a_idle", 20);
    check("s4_ovf_bal", last_bal, 100);
    check("s4_ovf_flags", 32'(last_flags), 32'b010);
    post(3, OP_NONE, 4, 7);
    wait_idle("s4b_idle", 20);
    check("s4_ill_bal", last_bal, 100);
    check("s4_ill_flags", 32'(last_flags), 32'b001);
    post(3, OP_BALANCE, 4, 0);
    wait_idle("s4c_idle", 20);
    check("s4_show_bal", last_bal, 100);

    // 5: all four at once, shared account
    grant_log.delete();
    grant_cyc_log.delete();
    post(0, OP_WITHDRAW, 5, 30);
    post(1, OP_BALANCE, 0, 0);
    post(2, OP_WITHDRAW, 5, 30);
    post(3, OP_DEPOSIT, 6, 1);
    wait_idle("s5_idle", 40);
    check("s5_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("s5_order", grant_log[i], i);
        if (i > 0) check("s5_spacing", grant_cyc_log[i] - grant_cyc_log[i-1], 3);
      end
    end
    check("s5_t0_bal", rsp_by_id[0], 70);
    check("s5_t2_bal", rsp_by_id[2], 40);

    // 6: reset during EXEC aborts the transaction
    post(1, OP_BALANCE, 0, 0);
    wait_idle("s6a_idle", 20);
    post(2, OP_DEPOSIT, 7, 5);
    begin
      int n = 0;
      while (bus.grant == '0 && n < 5) begin
        tick();
        n++;
      end
      check("s6_grant_seen", 32'(bus.grant), 32'h4);
    end
    do_reset();
    check("s6_rst_done", 32'(bus.done), 0);
    check("s6_rst_busy", 32'(bus.busy), 0);
    check("s6_rst_grant", 32'(bus.grant), 0);
    tick();
    tick();
    grant_log.delete();
    post(3, OP_BALANCE, 7, 0);
    post(1, OP_BALANCE, 1, 0);
    wait_idle("s6b_idle", 30);
    check("s6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    check("s6_card7_bal", rsp_by_id[3], 100);
    check("s6_card1_bal", rsp_by_id[1], 100);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int t = 0; t < N; t++) begin
        if (!pending[t] && $urandom_range(0, 3) == 0) begin
          card = $urandom_range(0, DEPTH - 1);
          case ($urandom_range(0, 3))
            0: amt = 0;
            1: amt = $urandom_range(0, 255);
            2: amt = $urandom_range(0, 40);
            default: amt = model_bank[card];
          endcase
          post(t, 2'($urandom_range(0, 3)), card, amt);
        end
      end
      tick();
    end
    wait_idle("rand_idle", 60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
